// File: rtl/audio_saw_period_meter.sv
// Sawtooth period meter: finds the wrap discontinuity of an 8-bit sample stream,
// counts clocks between wraps and tracks min/max amplitude, delivering results via valid/ready.
module audio_saw_period_meter #(
  parameter int unsigned CNT_WIDTH = 24,
  parameter int unsigned JUMP_THR  = 128,
  parameter bit          SAW_DIR   = 1'b0
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic                 enable_i,
  input  logic [7:0]           sample_data_i,
  output logic [CNT_WIDTH-1:0] period_o,
  output logic [7:0]           amp_min_o,
  output logic [7:0]           amp_max_o,
  output logic                 meas_valid_o,
  input  logic                 meas_ready_i,
  output logic                 locked_o,
  output logic                 drop_o,
  output logic                 timeout_o
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SYNC    = 2'd1,
    ST_MEASURE = 2'd2
  } state_e;

  localparam logic [CNT_WIDTH-1:0] CNT_ZERO   = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE    = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] CNT_MAX    = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_SAT_M1 = CNT_MAX - CNT_ONE;
  localparam logic [8:0]           THR        = 9'(JUMP_THR);

  // Difference is taken on the ordered operands only, so it never wraps around.
  function automatic logic detect_wrap(input logic [7:0] cur, input logic [7:0] prv);
    logic       ordered;
    logic [7:0] diff;
    if (SAW_DIR == 1'b0) begin
      ordered = (cur > prv);
      diff    = cur - prv;
    end else begin
      ordered = (prv > cur);
      diff    = prv - cur;
    end
    return ordered && ({1'b0, diff} >= THR);
  endfunction

  state_e               state_q, state_d;
  logic [7:0]           prev_q, prev_d;
  logic                 prev_valid_q, prev_valid_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [7:0]           min_q, min_d;
  logic [7:0]           max_q, max_d;
  logic [CNT_WIDTH-1:0] period_q, period_d;
  logic [7:0]           amp_min_q, amp_min_d;
  logic [7:0]           amp_max_q, amp_max_d;
  logic                 valid_q, valid_d;
  logic                 drop_q, drop_d;
  logic                 timeout_q, timeout_d;
  logic                 locked_q, locked_d;
  logic                 wrap_s;
  logic                 xfer_s;
  logic                 cand_s;

  // Next-state, measurement tracking and result register logic.
  always_comb begin
    state_d      = state_q;
    prev_d       = prev_q;
    prev_valid_d = prev_valid_q;
    cnt_d        = cnt_q;
    min_d        = min_q;
    max_d        = max_q;
    period_d     = period_q;
    amp_min_d    = amp_min_q;
    amp_max_d    = amp_max_q;
    valid_d      = valid_q;
    drop_d       = drop_q;
    timeout_d    = timeout_q;
    cand_s       = 1'b0;
    wrap_s       = prev_valid_q && detect_wrap(sample_data_i, prev_q);
    xfer_s       = valid_q && meas_ready_i;

    if (!enable_i) begin
      state_d      = ST_IDLE;
      prev_valid_d = 1'b0;
      cnt_d        = CNT_ZERO;
      min_d        = 8'd0;
      max_d        = 8'd0;
      drop_d       = 1'b0;
      timeout_d    = 1'b0;
    end else begin
      prev_d       = sample_data_i;
      prev_valid_d = 1'b1;
      case (state_q)
        ST_IDLE: begin
          state_d = ST_SYNC;
        end
        ST_SYNC: begin
          if (wrap_s) begin
            state_d = ST_MEASURE;
            cnt_d   = CNT_ZERO;
            min_d   = sample_data_i;
            max_d   = sample_data_i;
          end else begin
            state_d = ST_SYNC;
          end
        end
        ST_MEASURE: begin
          if (wrap_s) begin
            cand_s = 1'b1;
            cnt_d  = CNT_ZERO;
            min_d  = sample_data_i;
            max_d  = sample_data_i;
          end else if (cnt_q == CNT_SAT_M1) begin
            // Counter would hit all-ones: give up on this period and resync.
            cnt_d     = CNT_MAX;
            timeout_d = 1'b1;
            state_d   = ST_SYNC;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
            min_d = (sample_data_i < min_q) ? sample_data_i : min_q;
            max_d = (sample_data_i > max_q) ? sample_data_i : max_q;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    // A result slot is free if empty or being drained this very cycle.
    if (cand_s && (!valid_q || xfer_s)) begin
      period_d  = cnt_q + CNT_ONE;
      amp_min_d = min_q;
      amp_max_d = max_q;
      valid_d   = 1'b1;
    end else if (cand_s) begin
      drop_d = 1'b1;
    end else if (xfer_s) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end

    locked_d = (state_d == ST_MEASURE);
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q      <= ST_IDLE;
      prev_q       <= 8'd0;
      prev_valid_q <= 1'b0;
      cnt_q        <= CNT_ZERO;
      min_q        <= 8'd0;
      max_q        <= 8'd0;
      period_q     <= CNT_ZERO;
      amp_min_q    <= 8'd0;
      amp_max_q    <= 8'd0;
      valid_q      <= 1'b0;
      drop_q       <= 1'b0;
      timeout_q    <= 1'b0;
      locked_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      prev_q       <= prev_d;
      prev_valid_q <= prev_valid_d;
      cnt_q        <= cnt_d;
      min_q        <= min_d;
      max_q        <= max_d;
      period_q     <= period_d;
      amp_min_q    <= amp_min_d;
      amp_max_q    <= amp_max_d;
      valid_q      <= valid_d;
      drop_q       <= drop_d;
      timeout_q    <= timeout_d;
      locked_q     <= locked_d;
    end
  end

  assign period_o     = period_q;
  assign amp_min_o    = amp_min_q;
  assign amp_max_o    = amp_max_q;
  assign meas_valid_o = valid_q;
  assign locked_o     = locked_q;
  assign drop_o       = drop_q;
  assign timeout_o    = timeout_q;

endmodule

// File: tb/tb_audio_saw_period_meter.sv
// Bench for audio_saw_period_meter: scoreboard of expected results checked on each
// valid/ready transfer, plus directed checks on flags, timeout and reset behaviour.
module tb_audio_saw_period_meter;

  typedef struct packed {
    logic [23:0] p;
    logic [7:0]  mn;
    logic [7:0]  mx;
  } res_t;

  logic        clk = 1'b0;
  logic        rstn;
  logic        en, rdy;
  logic [7:0]  smp;
  logic [23:0] period;
  logic [7:0]  amin, amax;
  logic        valid, locked, drop, tmo;

  logic        en2, rdy2;
  logic [7:0]  s2;
  logic [7:0]  period2;
  logic [7:0]  amin2, amax2;
  logic        valid2, locked2, drop2, tmo2;

  res_t sbq[$];
  res_t exp_r;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  audio_saw_period_meter dut (
    .clk_i(clk), .rstn_i(rstn), .enable_i(en), .sample_data_i(smp),
    .period_o(period), .amp_min_o(amin), .amp_max_o(amax),
    .meas_valid_o(valid), .meas_ready_i(rdy), .locked_o(locked),
    .drop_o(drop), .timeout_o(tmo)
  );

  audio_saw_period_meter #(.CNT_WIDTH(8), .JUMP_THR(128), .SAW_DIR(1'b1)) dut2 (
    .clk_i(clk), .rstn_i(rstn), .enable_i(en2), .sample_data_i(s2),
    .period_o(period2), .amp_min_o(amin2), .amp_max_o(amax2),
    .meas_valid_o(valid2), .meas_ready_i(rdy2), .locked_o(locked2),
    .drop_o(drop2), .timeout_o(tmo2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic drive(input logic [7:0] s, input int n);
    repeat (n) begin
      smp = s;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic ramp_from(input int start, input int step);
    for (int v = start; v >= 0; v--) drive(8'(v), step);
  endtask

  task automatic drive2(input logic [7:0] s, input int n);
    repeat (n) begin
      s2 = s;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [23:0] p, input logic [7:0] mn, input logic [7:0] mx);
    exp_r.p  = p;
    exp_r.mn = mn;
    exp_r.mx = mx;
    sbq.push_back(exp_r);
  endtask

  // Monitor: every transfer on the main DUT must match the oldest expected result.
  always @(negedge clk) begin
    if (rstn && valid && rdy) begin
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_result: got period %0d min %0d max %0d, expected none", period, amin, amax);
      end else begin
        res_t e;
        e = sbq.pop_front();
        if (period !== e.p || amin !== e.mn || amax !== e.mx) begin
          errors++;
          $display("FAIL result: got period %0d min %0d max %0d, expected period %0d min %0d max %0d",
                   period, amin, amax, e.p, e.mn, e.mx);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rstn = 1'b0; en = 1'b0; rdy = 1'b0; smp = 8'd0;
    en2 = 1'b0; rdy2 = 1'b1; s2 = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", {31'd0, valid}, 32'd0);
    chk("rst_locked", {31'd0, locked}, 32'd0);
    chk("rst_period", {8'd0, period}, 32'd0);
    chk("rst_flags", {30'd0, drop, tmo}, 32'd0);
    chk("rst_amp", {16'd0, amin, amax}, 32'd0);
    rstn = 1'b1;
    drive(8'd0, 1);

    // A: inverted saw, step every 4 clocks, always ready.
    rdy = 1'b1; en = 1'b1;
    ramp_from(255, 4);
    drive(8'd255, 1);
    chk("A_no_valid_first_wrap", {31'd0, valid}, 32'd0);
    chk("A_locked", {31'd0, locked}, 32'd1);
    drive(8'd255, 3);
    ramp_from(254, 4);
    push(24'd1024, 8'd0, 8'd255);
    drive(8'd255, 1);
    chk("A_valid_pulse", {31'd0, valid}, 32'd1);
    drive(8'd255, 1);
    chk("A_valid_cleared", {31'd0, valid}, 32'd0);
    drive(8'd255, 2);
    ramp_from(254, 4);
    push(24'd1024, 8'd0, 8'd255);
    drive(8'd255, 2);

    // B: no ready across several wraps, result held, drop raised.
    rdy = 1'b0; en = 1'b0;
    drive(8'd0, 2);
    chk("B_idle_locked", {31'd0, locked}, 32'd0);
    en = 1'b1;
    ramp_from(255, 1);
    ramp_from(255, 1);
    push(24'd256, 8'd0, 8'd255);
    ramp_from(255, 1);
    chk("B_no_drop_yet", {31'd0, drop}, 32'd0);
    drive(8'd255, 1);
    chk("B_drop", {31'd0, drop}, 32'd1);
    chk("B_valid_held", {31'd0, valid}, 32'd1);
    chk("B_period_held", {8'd0, period}, 32'd256);
    chk("B_amp_held", {16'd0, amin, amax}, {16'd0, 8'd0, 8'd255});
    rdy = 1'b1;
    drive(8'd254, 1);
    rdy = 1'b0;
    chk("B_valid_after_xfer", {31'd0, valid}, 32'd0);
    chk("B_drop_sticky", {31'd0, drop}, 32'd1);

    // C: wrap coincides with transfer, new result replaces old without drop.
    en = 1'b0;
    drive(8'd0, 1);
    chk("C_drop_cleared", {31'd0, drop}, 32'd0);
    en = 1'b1;
    ramp_from(255, 1);
    ramp_from(255, 1);
    push(24'd256, 8'd0, 8'd255);
    ramp_from(255, 1);
    push(24'd256, 8'd0, 8'd255);
    rdy = 1'b1;
    drive(8'd255, 1);
    rdy = 1'b0;
    chk("C_valid_stays", {31'd0, valid}, 32'd1);
    chk("C_no_drop", {31'd0, drop}, 32'd0);
    rdy = 1'b1;
    drive(8'd254, 1);
    rdy = 1'b0;

    // D: disable mid-measure keeps pending result, clears flags.
    ramp_from(253, 1);
    push(24'd256, 8'd0, 8'd255);
    drive(8'd255, 1);
    ramp_from(254, 1);
    drive(8'd255, 1);
    chk("D_drop", {31'd0, drop}, 32'd1);
    drive(8'd254, 3);
    en = 1'b0;
    drive(8'd253, 1);
    chk("D_unlocked", {31'd0, locked}, 32'd0);
    chk("D_drop_cleared", {31'd0, drop}, 32'd0);
    chk("D_pending_valid", {31'd0, valid}, 32'd1);
    chk("D_pending_period", {8'd0, period}, 32'd256);
    rdy = 1'b1;
    drive(8'd0, 1);
    rdy = 1'b0;

    // E: jump threshold boundary, then a short period.
    en = 1'b1;
    drive(8'd10, 2);
    drive(8'd137, 1);
    chk("E_step127_no_wrap", {31'd0, locked}, 32'd0);
    drive(8'd0, 1);
    drive(8'd128, 1);
    chk("E_step128_wrap", {31'd0, locked}, 32'd1);
    drive(8'd128, 2);
    drive(8'd0, 2);
    drive(8'd200, 1);
    chk("E_valid", {31'd0, valid}, 32'd1);
    chk("E_period", {8'd0, period}, 32'd5);
    chk("E_amp", {16'd0, amin, amax}, {16'd0, 8'd0, 8'd128});

    // F: asynchronous reset mid-measure clears everything at once.
    rstn = 1'b0;
    #1;
    chk("F_valid", {31'd0, valid}, 32'd0);
    chk("F_locked", {31'd0, locked}, 32'd0);
    chk("F_period", {8'd0, period}, 32'd0);
    chk("F_amp", {16'd0, amin, amax}, 32'd0);
    chk("F_flags", {30'd0, drop, tmo}, 32'd0);
    en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    drive(8'd0, 1);

    // G: rising saw, 8-bit counter: first sample after enable, drop wrap, timeout.
    en2 = 1'b1;
    drive2(8'd200, 1);
    en2 = 1'b0;
    drive2(8'd200, 1);
    en2 = 1'b1;
    drive2(8'd10, 1);
    chk("G_first_no_wrap", {31'd0, locked2}, 32'd0);
    drive2(8'd10, 1);
    chk("G_sync_no_wrap", {31'd0, locked2}, 32'd0);
    drive2(8'd200, 1);
    drive2(8'd10, 1);
    chk("G_drop_is_wrap", {31'd0, locked2}, 32'd1);
    drive2(8'd10, 254);
    chk("G_still_locked", {31'd0, locked2}, 32'd1);
    chk("G_no_timeout_yet", {31'd0, tmo2}, 32'd0);
    drive2(8'd10, 1);
    chk("G_timeout", {31'd0, tmo2}, 32'd1);
    chk("G_unlocked", {31'd0, locked2}, 32'd0);
    chk("G_no_valid", {31'd0, valid2}, 32'd0);
    drive2(8'd10, 3);
    chk("G_still_sync", {30'd0, locked2, valid2}, 32'd0);
    en2 = 1'b0;
    drive2(8'd10, 1);
    chk("G_timeout_cleared", {31'd0, tmo2}, 32'd0);

    chk("scoreboard_empty", sbq.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/audio_saw_period_meter.md
Name: audio_saw_period_meter

Overview:
Sample-stream analyser at the consuming end of the wave generators' 8-bit sample bus. It detects the wrap discontinuity of a sawtooth (inverted or rising) and measures the period in clock cycles, plus min/max amplitude per period. Each result is delivered through a valid/ready output register. It is used in synth self-test and for frequency read-back of generator outputs.

Parameters:
CNT_WIDTH, 24, width of the period counter and period_o.
JUMP_THR, 128, minimum absolute sample step (unsigned 8-bit) that counts as a wrap.
SAW_DIR, 0, 0 = inverted saw (wrap is an upward jump); 1 = rising saw (wrap is a downward jump).

Ports:
clk_i  input  1  clock.
rstn_i  input  1  asynchronous active-low reset.
enable_i  input  1  measurement enable; low forces IDLE.
sample_data_i  input  8  unsigned sample from a generator.
period_o  output  CNT_WIDTH  measured period, in clocks.
amp_min_o  output  8  minimum sample in the reported period.
amp_max_o  output  8  maximum sample in the reported period.
meas_valid_o  output  1  result register holds an unconsumed result.
meas_ready_i  input  1  consumer accepts the result when meas_valid_o is high.
locked_o  output  1  high while the FSM is in MEASURE.
drop_o  output  1  sticky flag: a result was lost to back-pressure.
timeout_o  output  1  sticky flag: the period counter saturated.

Behaviour:
- Reset is asynchronous, active-low (rstn_i); the clock is clk_i.
- Reset values: all outputs 0; FSM in IDLE; internal prev sample 0; prev_valid 0.
- Each cycle with enable_i=1:
  - prev <= sample_data_i.
  - prev_valid <= 1.
- Wrap detection is combinational and requires prev_valid=1:
  - SAW_DIR=0: sample_data_i > prev and (sample_data_i - prev) >= JUMP_THR.
  - SAW_DIR=1: prev > sample_data_i and (prev - sample_data_i) >= JUMP_THR.
  - Subtraction is 8-bit unsigned on the ordered operands; no wrap-around.
- FSM states:
  - IDLE: entered whenever enable_i=0 (any state, next cycle). Clears prev_valid, counter, min/max, drop_o and timeout_o. The pending result register and meas_valid_o are preserved. IDLE -> SYNC when enable_i=1.
  - SYNC: wait for a wrap. On wrap, go to MEASURE with cnt <= 0, min <= max <= sample_data_i. No result is produced.
  - MEASURE, non-wrap cycle:
    - cnt <= cnt+1, saturating at all-ones.
    - min/max updated with sample_data_i.
  - MEASURE, wrap cycle:
    - Candidate result is period = cnt+1 (the cycle distance between the two wrap samples), min/max = tracked values (which exclude the current sample).
    - cnt <= 0 and min <= max <= sample_data_i; the wrap sample begins the new period.
    - State stays MEASURE.
  - Saturation: if cnt reaches all-ones in MEASURE with no wrap, set timeout_o and go to SYNC. No result is produced.
- Result register:
  - The candidate is loaded the cycle after the wrap sample (1-clock latency), if meas_valid_o=0 or (meas_valid_o & meas_ready_i) in the wrap cycle.
  - On load, meas_valid_o = 1.
  - Otherwise the old result is kept, the new one is discarded, and drop_o is set.
  - Handshake: meas_valid_o & meas_ready_i transfers the result. Without a simultaneous load, meas_valid_o clears next cycle.
  - While meas_valid_o=1, period_o/amp_min_o/amp_max_o are stable until transfer.
- locked_o = (state == MEASURE), registered with the state.
- Reset mid-measurement: immediate return to reset values, including the result register.

Test Plan:
- SAW_DIR=0; stimulus counts from 255 down to 0, stepping every 4 clocks, then wraps to 255; meas_ready_i=1 -> first result after the second wrap: period_o=1024, amp_min_o=0, amp_max_o=255; meas_valid_o pulses 1 cycle, one cycle after each wrap sample.
- Same stimulus with meas_ready_i=0 over 3 wraps -> first result held stable, drop_o=1 after the second result wrap; raising ready for 1 cycle -> meas_valid_o=0 next cycle.
- Wrap coincides with valid&ready -> new result loaded, meas_valid_o stays 1, drop_o stays 0.
- CNT_WIDTH=8, constant sample 100 after one wrap -> timeout_o=1 after 255 cycles in MEASURE, state SYNC, locked_o=0, no valid.
- Step of 127 with JUMP_THR=128 -> no wrap; step of 128 -> wrap detected. SAW_DIR=1: a 200->10 drop is a wrap; the first sample after enable never triggers a wrap.
- Toggle enable_i low mid-MEASURE -> locked_o=0 next cycle, flags cleared, pending result kept. Assert rstn_i low mid-MEASURE -> all outputs 0 at once.
